// File: rtl/ldsync_pkg.sv
// Shared types and helpers for the load-sync arbiter.
package ldsync_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StAck
    } state_e;

    // Ceiling log2 for elaboration-time width calculations.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: first set request at or above ptr_i, wrapping modulo N.
module rr_pick
    import ldsync_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = (clog2(N) > 0) ? clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    // Scan from the farthest slot back to ptr so the nearest set request wins.
    always_comb begin
        int unsigned s;
        logic [IW-1:0] j;
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = 32'(ptr_i) + 32'(k);
            if (s >= N) begin
                s = s - N;
            end
            j = IW'(s);
            if (req_i[j]) begin
                valid_o = 1'b1;
                idx_o   = j;
            end
        end
    end

endmodule

// File: rtl/ldsync_arb.sv
// Round-robin load arbiter and sequencer for a bank of loadable sync registers.
module ldsync_arb
    import ldsync_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned AW    = 3,
    parameter int unsigned NREGS = 8,
    parameter int unsigned DW    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 lock,
    output logic [NREGS-1:0]     ld,
    output logic [DW-1:0]        d,
    output logic [NREQ-1:0]      ack,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned IW = (clog2(NREQ) > 0) ? clog2(NREQ) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] win_q, win_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          err_q, err_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          grant;
    logic          addr_ok;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign grant   = (state_q == StIdle) && !lock && pick_valid;
    assign addr_ok = 32'(addr_q) < NREGS;

    // State and captured-transaction registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            win_q    <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            rr_ptr_q <= rr_ptr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // Next-state: lock only gates leaving IDLE; LOAD and ACK always run to completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant) state_d = StLoad;
            StLoad:  state_d = StAck;
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Capture winner on grant, flag bad addresses in LOAD, advance pointer past winner in ACK.
    always_comb begin
        win_d    = win_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q;
        if (grant) begin
            win_d = pick_idx;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (pick_idx == IW'(i)) begin
                    addr_d = req_addr[i*AW +: AW];
                    data_d = req_data[i*DW +: DW];
                end
            end
        end
        if ((state_q == StLoad) && !addr_ok) begin
            err_d = 1'b1;
        end
        if (state_q == StAck) begin
            rr_ptr_d = (32'(win_q) == NREQ - 1) ? '0 : win_q + IW'(1);
        end
    end

    // Outputs decoded from registered state only; no path from req to ld or ack.
    always_comb begin
        ld = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            ld[r] = (state_q == StLoad) && (addr_q == AW'(r));
        end
        ack = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            ack[i] = (state_q == StAck) && (win_q == IW'(i));
        end
        busy = (state_q != StIdle);
        d    = data_q;
        err  = err_q;
    end

endmodule

// File: tb/tb_ldsync_arb.sv
// Self-checking bench for ldsync_arb: transaction-level model plus directed scenarios.
module tb_ldsync_arb;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned AW    = 3;
    localparam int unsigned NREGS = 6;
    localparam int unsigned DW    = 16;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic                lock;
    logic [NREGS-1:0]    ld;
    logic [DW-1:0]       d;
    logic [NREQ-1:0]     ack;
    logic                busy;
    logic                err;

    int tests;
    int fails;

    ldsync_arb #(
        .NREQ  (NREQ),
        .AW    (AW),
        .NREGS (NREGS),
        .DW    (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .lock     (lock),
        .ld       (ld),
        .d        (d),
        .ack      (ack),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: a pending transaction is "how many cycles since grant".
    int unsigned   m_age;      // 0 none, 1 load cycle, 2 ack cycle
    int unsigned   m_win;
    int unsigned   m_ptr;
    int unsigned   m_addr;
    logic [DW-1:0] m_data;
    logic          m_err;

    always @(posedge clk or posedge rst) begin
        bit found;
        int unsigned j;
        if (rst) begin
            m_age  = 0;
            m_win  = 0;
            m_ptr  = 0;
            m_addr = 0;
            m_data = '0;
            m_err  = 1'b0;
        end else if (m_age == 0) begin
            found = 1'b0;
            if (!lock) begin
                for (int k = 0; k < NREQ; k++) begin
                    j = (m_ptr + k) % NREQ;
                    if (!found && req[j]) begin
                        found  = 1'b1;
                        m_win  = j;
                        m_addr = req_addr[j*AW +: AW];
                        m_data = req_data[j*DW +: DW];
                    end
                end
            end
            if (found) m_age = 1;
        end else if (m_age == 1) begin
            if (m_addr >= NREGS) m_err = 1'b1;
            m_age = 2;
        end else begin
            m_ptr = (m_win + 1) % NREQ;
            m_age = 0;
        end
    end

    // Every cycle, compare all outputs against the model.
    always @(negedge clk) begin
        logic [NREGS-1:0] e_ld;
        logic [NREQ-1:0]  e_ack;
        e_ld  = '0;
        e_ack = '0;
        if (m_age == 1 && m_addr < NREGS) e_ld[m_addr] = 1'b1;
        if (m_age == 2) e_ack[m_win] = 1'b1;
        chk("model_ld", 32'(ld), 32'(e_ld));
        chk("model_ack", 32'(ack), 32'(e_ack));
        chk("model_d", 32'(d), 32'(m_data));
        chk("model_busy", 32'(busy), 32'(m_age != 0));
        chk("model_err", 32'(err), 32'(m_err));
    end

    task automatic set_req(input int i, input int a, input logic [DW-1:0] dat);
        req[i]               = 1'b1;
        req_addr[i*AW +: AW] = AW'(a);
        req_data[i*DW +: DW] = dat;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    int ord[$];
    logic [NREGS-1:0] lds[$];

    initial begin
        logic [NREQ-1:0] a;
        tests    = 0;
        fails    = 0;
        rst      = 1'b1;
        lock     = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ld", 32'(ld), 32'h0);
        chk("rst_d", 32'(d), 32'h0);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        #1 rst = 1'b0;

        // Single request from requester 2
        @(negedge clk);
        #1 set_req(2, 5, 16'hBEEF);
        @(negedge clk);
        chk("single_ld", 32'(ld), 32'h20);
        chk("single_d", 32'(d), 32'hBEEF);
        chk("single_busy_load", 32'(busy), 32'h1);
        @(negedge clk);
        chk("single_ack", 32'(ack), 32'h4);
        chk("single_busy_ack", 32'(busy), 32'h1);
        #1 req = '0;
        @(negedge clk);
        chk("single_busy_done", 32'(busy), 32'h0);

        // Contention with all four requesting from rr_ptr=0
        #1 pulse_rst();
        for (int i = 0; i < NREQ; i++) set_req(i, i, 16'h1000 + 16'(i));
        ord.delete();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            a = ack;
            for (int i = 0; i < NREQ; i++) if (a[i]) ord.push_back(i);
            #1 req = req & ~a;
        end
        chk("cont_count", 32'(ord.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("cont_order", 32'(ord[i]), 32'(i));
        @(negedge clk);
        chk("cont_idle", 32'(busy), 32'h0);

        // Fairness: requester 0 keeps requesting, 3 must be served second
        #1 set_req(0, 1, 16'h2000);
        set_req(3, 2, 16'h2003);
        ord.delete();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            a = ack;
            for (int i = 0; i < NREQ; i++) if (a[i]) ord.push_back(i);
            #1 req[3] = req[3] & ~a[3];
        end
        #1 req = '0;
        chk("fair_first", 32'(ord[0]), 32'd0);
        chk("fair_second", 32'(ord[1]), 32'd3);
        @(negedge clk);
        @(negedge clk);

        // Lock holds off the grant, then raised during LOAD does not stop ACK
        #1 lock = 1'b1;
        set_req(1, 4, 16'h3001);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("lock_hold_ld", 32'(ld), 32'h0);
        end
        #1 lock = 1'b0;
        @(negedge clk);
        chk("lock_release_ld", 32'(ld), 32'h10);
        chk("lock_release_d", 32'(d), 32'h3001);
        #1 lock = 1'b1;
        @(negedge clk);
        chk("lock_ack", 32'(ack), 32'h2);
        #1 req = '0;
        lock = 1'b0;
        @(negedge clk);
        chk("lock_idle", 32'(busy), 32'h0);

        // Out-of-range address: no strobe, still acked, err sticks
        #1 set_req(2, 7, 16'h1234);
        @(negedge clk);
        chk("oor_ld", 32'(ld), 32'h0);
        chk("oor_err_load", 32'(err), 32'h0);
        @(negedge clk);
        chk("oor_ack", 32'(ack), 32'h4);
        chk("oor_err_set", 32'(err), 32'h1);
        #1 req = '0;
        @(negedge clk);
        #1 set_req(1, 3, 16'h0055);
        @(negedge clk);
        chk("oor_valid_ld", 32'(ld), 32'h08);
        chk("oor_err_held", 32'(err), 32'h1);
        @(negedge clk);
        chk("oor_valid_ack", 32'(ack), 32'h2);
        #1 req = '0;
        @(negedge clk);
        chk("oor_err_still", 32'(err), 32'h1);

        // Reset during LOAD aborts immediately; both requests served after, from ptr 0
        #1 set_req(3, 2, 16'hAAAA);
        @(negedge clk);
        chk("mid_ld_before", 32'(ld), 32'h04);
        #1 rst = 1'b1;
        #1;
        chk("mid_ld_drop", 32'(ld), 32'h0);
        chk("mid_ack_drop", 32'(ack), 32'h0);
        chk("mid_busy_drop", 32'(busy), 32'h0);
        chk("mid_err_clr", 32'(err), 32'h0);
        set_req(1, 1, 16'h1111);
        @(negedge clk);
        chk("mid_ld_in_rst", 32'(ld), 32'h0);
        #1 rst = 1'b0;
        ord.delete();
        lds.delete();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            a = ack;
            if (ld != '0) lds.push_back(ld);
            for (int i = 0; i < NREQ; i++) if (a[i]) ord.push_back(i);
            #1 req = req & ~a;
        end
        chk("mid_count", 32'(ord.size()), 32'd2);
        chk("mid_first", 32'(ord[0]), 32'd1);
        chk("mid_second", 32'(ord[1]), 32'd3);
        chk("mid_first_ld", 32'(lds[0]), 32'h02);
        chk("mid_second_ld", 32'(lds[1]), 32'h04);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
